// File: rtl/calc_pkg.sv
// Shared types for the push-button accumulator calculator: FSM states,
// error codes, operation encoding and the button priority encoder.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIV_RUN,
    ERR_BLINK
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_UNF  = 2'd2;
  localparam logic [1:0] ERR_DIV0 = 2'd3;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_LOAD,
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_DIV
  } op_e;

  localparam int unsigned NUM_BTN = 5;
  localparam int unsigned BTN_C   = 0;
  localparam int unsigned BTN_D   = 1;
  localparam int unsigned BTN_U   = 2;
  localparam int unsigned BTN_L   = 3;
  localparam int unsigned BTN_R   = 4;

  // Highest-priority pulse wins; lower-priority simultaneous pulses are dropped.
  function automatic op_e pick_op(input logic [NUM_BTN-1:0] pulse);
    op_e op;
    if (pulse[BTN_C])      op = OP_LOAD;
    else if (pulse[BTN_D]) op = OP_ADD;
    else if (pulse[BTN_U]) op = OP_SUB;
    else if (pulse[BTN_L]) op = OP_MUL;
    else if (pulse[BTN_R]) op = OP_DIV;
    else                   op = OP_NONE;
    return op;
  endfunction

endpackage

// File: rtl/calc_accum_ctrl_if.sv
// Board-side bundle of the calculator: operand switches, push buttons,
// LED display and status outputs.
interface calc_accum_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] sw;
  logic             btnC;
  logic             btnD;
  logic             btnU;
  logic             btnL;
  logic             btnR;
  logic [WIDTH-1:0] led;
  logic             busy;
  logic [1:0]       err_code;

  modport master (
    output sw, btnC, btnD, btnU, btnL, btnR,
    input  led, busy, err_code
  );

  modport slave (
    input  sw, btnC, btnD, btnU, btnL, btnR,
    output led, busy, err_code
  );
endinterface

// File: rtl/calc_seq_divider.sv
// Restoring sequential divider: one quotient bit per cycle, done pulses
// WIDTH cycles after the start edge.
module calc_seq_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   rem_sh;

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    // quo_q doubles as the dividend shift register while bits are consumed
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    if (start) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
      cnt_d = CNT_W'(WIDTH);
      run_d = 1'b1;
    end else if (run_q) begin
      if (rem_sh >= {1'b0, dvs_q}) begin
        rem_d = WIDTH'(rem_sh - {1'b0, dvs_q});
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = done_q;
endmodule

// File: rtl/calc_accum_ctrl.sv
// Push-button accumulator calculator: synchronised one-shot buttons drive
// load/add/sub/mul/div on an accumulator shown on the LEDs, with a blink error display.
module calc_accum_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned BLINK_DIV_LOG2 = 25,
  parameter int unsigned BLINK_TOGGLES  = 10
) (
  input  logic           clk,
  input  logic           rst,
  calc_accum_ctrl_if.slave io
);
  localparam int unsigned TOG_W = $clog2(BLINK_TOGGLES + 1);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] pulse;
  logic [WIDTH-1:0]   sw_q;

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        acc_q, acc_d;
  logic [WIDTH-1:0]        led_q, led_d;
  logic                    busy_q, busy_d;
  logic [1:0]              err_q, err_d;
  logic [BLINK_DIV_LOG2-1:0] presc_q, presc_d;
  logic [TOG_W-1:0]        tog_q, tog_d;

  op_e              op;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] prod;
  logic             fail;
  logic [1:0]       fail_code;
  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem_unused;

  assign btn_raw = {io.btnR, io.btnL, io.btnU, io.btnD, io.btnC};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    logic s1_q, s2_q, prev_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q   <= 1'b0;
        s2_q   <= 1'b0;
        prev_q <= 1'b0;
      end else begin
        s1_q   <= btn_raw[i];
        s2_q   <= s1_q;
        prev_q <= s2_q;
      end
    end
    assign pulse[i] = s2_q & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) sw_q <= '0;
    else     sw_q <= io.sw;
  end

  calc_seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (acc_q),
    .divisor   (sw_q),
    .quotient  (div_quo),
    .remainder (div_rem_unused),
    .done      (div_done)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    led_d     = led_q;
    busy_d    = busy_q;
    err_d     = err_q;
    presc_d   = presc_q;
    tog_d     = tog_q;
    div_start = 1'b0;
    fail      = 1'b0;
    fail_code = ERR_NONE;
    op        = pick_op(pulse);
    sum       = {1'b0, acc_q} + {1'b0, sw_q};
    prod      = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, sw_q};

    unique case (state_q)
      IDLE: begin
        led_d  = acc_q;
        busy_d = 1'b0;
        unique case (op)
          OP_LOAD: begin
            acc_d = sw_q;
            err_d = ERR_NONE;
          end
          OP_ADD: begin
            if (sum[WIDTH]) begin
              fail = 1'b1; fail_code = ERR_OVF;
            end else begin
              acc_d = sum[WIDTH-1:0];
              err_d = ERR_NONE;
            end
          end
          OP_SUB: begin
            if (sw_q > acc_q) begin
              fail = 1'b1; fail_code = ERR_UNF;
            end else begin
              acc_d = acc_q - sw_q;
              err_d = ERR_NONE;
            end
          end
          OP_MUL: begin
            if (|prod[2*WIDTH-1:WIDTH]) begin
              fail = 1'b1; fail_code = ERR_OVF;
            end else begin
              acc_d = prod[WIDTH-1:0];
              err_d = ERR_NONE;
            end
          end
          OP_DIV: begin
            if (sw_q == '0) begin
              fail = 1'b1; fail_code = ERR_DIV0;
            end else begin
              div_start = 1'b1;
              state_d   = DIV_RUN;
              busy_d    = 1'b1;
              err_d     = ERR_NONE;
            end
          end
          default: ;
        endcase
        if (fail) begin
          err_d   = fail_code;
          state_d = ERR_BLINK;
          busy_d  = 1'b1;
          led_d   = '1;
          presc_d = '0;
          tog_d   = '0;
        end
      end
      DIV_RUN: begin
        led_d = acc_q;
        if (div_done) begin
          acc_d   = div_quo;
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      ERR_BLINK: begin
        // the last inversion stays visible for one cycle before acc returns
        if (tog_q == TOG_W'(BLINK_TOGGLES)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          led_d   = acc_q;
        end else begin
          presc_d = presc_q + BLINK_DIV_LOG2'(1);
          if (presc_q == '1) begin
            led_d = ~led_q;
            tog_d = tog_q + TOG_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= ERR_NONE;
      presc_q <= '0;
      tog_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      presc_q <= presc_d;
      tog_q   <= tog_d;
    end
  end

  assign io.led      = led_q;
  assign io.busy     = busy_q;
  assign io.err_code = err_q;
endmodule
